// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the parametrised VGA raster timing generator.
// Default segment lengths describe the standard 640x480@60 raster.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // Sync polarity: the level the pin takes while the sync pulse is active
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Raster attributes of one pixel position, carried down the latency line
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } raster_tag_t;

  // Length of one axis: active + front porch + sync + back porch
  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA640_H_TOTAL = seg_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int VGA640_V_TOTAL = seg_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each step and flags the last position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = VGA640_H_TOTAL,
  parameter int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST_POS = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last_o  = (count_q == LAST_POS);
  assign count_o = count_q;

  // Advance on step, wrapping from the last position back to zero
  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: pixel-rate divider, H/V raster, fetch
// request stage and a latency line that keeps sync/blank/rgb aligned with the
// pixel data returned FETCH_LAT ticks after each request.
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter int PIX_DIV   = 4,
  parameter int RGB_W     = 8,
  parameter int FETCH_LAT = 1,
  parameter bit HS_POL    = SYNC_ACTIVE_LOW,
  parameter bit VS_POL    = SYNC_ACTIVE_LOW,
  localparam int H_TOTAL  = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HC_W     = $clog2(H_TOTAL),
  localparam int VC_W     = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [RGB_W-1:0] next_rgb,
  output logic             request,
  output logic [HC_W-1:0]  hcount,
  output logic [VC_W-1:0]  vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [HC_W-1:0] H_ACT_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG    = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_ACT_END = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG    = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  logic [HC_W-1:0]  h;
  logic [VC_W-1:0]  v;
  logic             h_last;
  logic             v_last;

  logic             request_q, request_d;
  logic [HC_W-1:0]  hcount_q, hcount_d;
  logic [VC_W-1:0]  vcount_q, vcount_d;
  logic             frame_start_q, frame_start_d;
  logic             at_origin_q, at_origin_d;

  raster_tag_t      fetch_tag;
  raster_tag_t      disp_tag;
  raster_tag_t      dly_q [FETCH_LAT];
  raster_tag_t      dly_d [FETCH_LAT];

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  assign tick = en && (div_q == DIV_LAST);

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(HC_W)) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (tick),
    .count_o (h),
    .last_o  (h_last)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(VC_W)) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (tick && h_last),
    .count_o (v),
    .last_o  (v_last)
  );

  assign fetch_tag.active = (h < H_ACT_END) && (v < V_ACT_END);
  assign fetch_tag.hs     = (h >= HS_BEG) && (h < HS_END);
  assign fetch_tag.vs     = (v >= VS_BEG) && (v < VS_END);
  assign disp_tag         = dly_q[FETCH_LAT-1];

  // Pixel divider: counts only while enabled and restarts on every tick
  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  // Fetch stage: request and coordinates for the position being walked now
  always_comb begin
    request_d     = tick && fetch_tag.active;
    hcount_d      = request_d ? h : hcount_q;
    vcount_d      = request_d ? v : vcount_q;
    frame_start_d = tick && at_origin_q;
    at_origin_d   = tick ? (h_last && v_last) : at_origin_q;
  end

  // Latency line: shifts the raster tag once per tick so display matches data
  always_comb begin
    dly_d = dly_q;
    if (tick) begin
      dly_d[0] = fetch_tag;
      for (int i = 1; i < FETCH_LAT; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  // Display stage: combine the delayed tag with the returned pixel
  always_comb begin
    rgb_d   = rgb_q;
    blank_d = blank_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      rgb_d   = disp_tag.active ? next_rgb : '0;
      blank_d = !disp_tag.active;
      hsync_d = disp_tag.hs ? HS_POL : !HS_POL;
      vsync_d = disp_tag.vs ? VS_POL : !VS_POL;
    end
  end

  // State registers for divider, fetch, latency line and display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      request_q     <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      at_origin_q   <= 1'b1;
      for (int i = 0; i < FETCH_LAT; i++) begin
        dly_q[i] <= '0;
      end
      rgb_q         <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= !HS_POL;
      vsync_q       <= !VS_POL;
    end else begin
      div_q         <= div_d;
      request_q     <= request_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      at_origin_q   <= at_origin_d;
      dly_q         <= dly_d;
      rgb_q         <= rgb_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign request     = request_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Self-checking bench for vga_timing_gen_param: default 640x480 line timing,
// a small raster with 3-tick fetch latency and an enable gap, and an
// asynchronous reset taken in the middle of vsync on a tiny raster.
module tb_vga_timing_gen_param;

  localparam int B_HA = 16, B_HF = 4, B_HS = 6, B_HB = 4, B_HT = 30;
  localparam int B_VA = 8,  B_VF = 2, B_VS = 2, B_VB = 3, B_VT = 15;
  localparam int B_PD = 2,  B_L = 3;
  localparam int B_DROP = 917;

  typedef struct packed {
    logic       blank;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } dispExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  dispExp_t dispQ[$];

  logic       rstnA = 1'b1, enA = 1'b1;
  logic [7:0] nextA = 8'h3C;
  logic       reqA, hsA, vsA, blankA, fsA;
  logic [9:0] hcA, vcA;
  logic [7:0] rgbA;

  logic       rstnB = 1'b1, enB = 1'b1;
  logic [7:0] nextB = 8'hA5;
  logic       reqB, hsB, vsB, blankB, fsB;
  logic [4:0] hcB;
  logic [3:0] vcB;
  logic [7:0] rgbB;

  logic       rstnC = 1'b1, enC = 1'b1;
  logic [7:0] nextC = 8'h5A;
  logic       reqC, hsC, vsC, blankC, fsC;
  logic [3:0] hcC;
  logic [2:0] vcC;
  logic [7:0] rgbC;

  vga_timing_gen_param dutA (
    .clk(clk), .rst_n(rstnA), .en(enA), .next_rgb(nextA),
    .request(reqA), .hcount(hcA), .vcount(vcA), .hsync(hsA), .vsync(vsA),
    .blank(blankA), .rgb(rgbA), .frame_start(fsA)
  );

  vga_timing_gen_param #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .PIX_DIV(B_PD), .RGB_W(8), .FETCH_LAT(B_L), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutB (
    .clk(clk), .rst_n(rstnB), .en(enB), .next_rgb(nextB),
    .request(reqB), .hcount(hcB), .vcount(vcB), .hsync(hsB), .vsync(vsB),
    .blank(blankB), .rgb(rgbB), .frame_start(fsB)
  );

  vga_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(1), .RGB_W(8), .FETCH_LAT(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutC (
    .clk(clk), .rst_n(rstnC), .en(enC), .next_rgb(nextC),
    .request(reqC), .hcount(hcC), .vcount(vcC), .hsync(hsC), .vsync(vsC),
    .blank(blankC), .rgb(rgbC), .frame_start(fsC)
  );

  // Reset values of the default instance while reset is held
  task automatic test_reset;
    #2;
    rstnA = 1'b0;
    rstnB = 1'b0;
    rstnC = 1'b0;
    #1;
    checks++; if (reqA !== 1'b0)   begin errors++; $display("[TB] FAIL rst_request: got %b expected 0", reqA); end
    checks++; if (hcA !== 10'd0)   begin errors++; $display("[TB] FAIL rst_hcount: got %0d expected 0", hcA); end
    checks++; if (vcA !== 10'd0)   begin errors++; $display("[TB] FAIL rst_vcount: got %0d expected 0", vcA); end
    checks++; if (rgbA !== 8'd0)   begin errors++; $display("[TB] FAIL rst_rgb: got %h expected 00", rgbA); end
    checks++; if (blankA !== 1'b1) begin errors++; $display("[TB] FAIL rst_blank: got %b expected 1", blankA); end
    checks++; if (fsA !== 1'b0)    begin errors++; $display("[TB] FAIL rst_frame_start: got %b expected 0", fsA); end
    checks++; if (hsA !== 1'b1)    begin errors++; $display("[TB] FAIL rst_hsync: got %b expected 1", hsA); end
    checks++; if (vsA !== 1'b1)    begin errors++; $display("[TB] FAIL rst_vsync: got %b expected 1", vsA); end
  endtask

  // Default raster: request cadence, first line coordinates, hsync placement
  task automatic test_default_line;
    int firstReq = -1, firstActive = -1, line1First = -1;
    int reqLine0 = 0, badSeq = 0, badRgb = 0, badVs = 0, fsCount = 0;
    int prevH = 0, prevCyc = 0;
    int falls[$];
    int rises[$];
    logic prevHs;
    logic [9:0] line1H = 10'h3FF;
    @(negedge clk);
    rstnA = 1'b1;
    prevHs = hsA;
    for (int cyc = 1; cyc <= 6800; cyc++) begin
      @(negedge clk);
      if (reqA) begin
        if (firstReq < 0) begin
          firstReq = cyc;
          checks++; if (hcA !== 10'd0 || vcA !== 10'd0)
            begin errors++; $display("[TB] FAIL a_first_coord: got (%0d,%0d) expected (0,0)", hcA, vcA); end
          checks++; if (fsA !== 1'b1)
            begin errors++; $display("[TB] FAIL a_first_frame_start: got %b expected 1", fsA); end
        end else if (vcA == 10'd0) begin
          if (int'(hcA) != prevH + 1 || cyc - prevCyc != 4) badSeq++;
        end
        if (vcA == 10'd0) reqLine0++;
        if (vcA == 10'd1 && line1First < 0) begin
          line1First = cyc;
          line1H = hcA;
        end
        prevH = int'(hcA);
        prevCyc = cyc;
      end
      if (fsA) fsCount++;
      if (!blankA && firstActive < 0) firstActive = cyc;
      if ((!blankA && rgbA !== 8'h3C) || (blankA && rgbA !== 8'h00)) badRgb++;
      if (vsA !== 1'b1) badVs++;
      if (prevHs && !hsA) falls.push_back(cyc);
      if (!prevHs && hsA) rises.push_back(cyc);
      prevHs = hsA;
    end
    checks++; if (firstReq != 4)     begin errors++; $display("[TB] FAIL a_first_req_cyc: got %0d expected 4", firstReq); end
    checks++; if (reqLine0 != 640)   begin errors++; $display("[TB] FAIL a_line0_requests: got %0d expected 640", reqLine0); end
    checks++; if (badSeq != 0)       begin errors++; $display("[TB] FAIL a_hcount_sequence: got %0d bad steps expected 0", badSeq); end
    checks++; if (fsCount != 1)      begin errors++; $display("[TB] FAIL a_frame_start_count: got %0d expected 1", fsCount); end
    checks++; if (firstActive != 8)  begin errors++; $display("[TB] FAIL a_first_display_cyc: got %0d expected 8", firstActive); end
    checks++; if (line1First != 3204 || line1H !== 10'd0)
      begin errors++; $display("[TB] FAIL a_line1_start: got cyc %0d h %0d expected cyc 3204 h 0", line1First, line1H); end
    checks++; if (badRgb != 0)       begin errors++; $display("[TB] FAIL a_rgb_blanking: got %0d bad samples expected 0", badRgb); end
    checks++; if (badVs != 0)        begin errors++; $display("[TB] FAIL a_vsync_idle: got %0d bad samples expected 0", badVs); end
    checks++;
    if (falls.size() < 2 || rises.size() < 1) begin
      errors++; $display("[TB] FAIL a_hsync_edges: got %0d falls %0d rises expected >=2 and >=1", falls.size(), rises.size());
    end else begin
      checks++; if (falls[0] != 2632)
        begin errors++; $display("[TB] FAIL a_hsync_fall: got cyc %0d expected 2632", falls[0]); end
      checks++; if (rises[0] - falls[0] != 384)
        begin errors++; $display("[TB] FAIL a_hsync_width: got %0d clk expected 384", rises[0] - falls[0]); end
      checks++; if (falls[1] - falls[0] != 3200)
        begin errors++; $display("[TB] FAIL a_line_period: got %0d clk expected 3200", falls[1] - falls[0]); end
    end
  endtask

  // Small raster, 3-tick fetch latency, 37-clk enable gap; display scoreboard
  task automatic test_fetch_latency_en;
    int bDiv = 0, hM = 0, vM = 0, tickIdx = 0, reqInFrame = 0;
    logic [7:0] fbMem [8];
    int fsTimes[$];
    logic enUsed, tickNow, act, expReq, expFs;
    dispExp_t exp, held, nxt;
    for (int i = 0; i < 8; i++) fbMem[i] = 8'hA5;
    dispQ.delete();
    for (int i = 0; i < B_L; i++) dispQ.push_back('{blank: 1'b1, hs: 1'b1, vs: 1'b1, rgb: 8'h00});
    held = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, rgb: 8'h00};
    @(negedge clk);
    rstnB = 1'b1;
    enB = 1'b1;
    nextB = fbMem[1];
    for (int cyc = 1; cyc <= 2760; cyc++) begin
      enUsed = enB;
      @(negedge clk);
      tickNow = enUsed && (bDiv == B_PD - 1);
      if (enUsed) bDiv = tickNow ? 0 : bDiv + 1;
      act = (hM < B_HA) && (vM < B_VA);
      expReq = tickNow && act;
      expFs = tickNow && hM == 0 && vM == 0;
      checks++; if (reqB !== expReq)
        begin errors++; $display("[TB] FAIL b_request cyc %0d: got %b expected %b", cyc, reqB, expReq); end
      checks++; if (fsB !== expFs)
        begin errors++; $display("[TB] FAIL b_frame_start cyc %0d: got %b expected %b", cyc, fsB, expFs); end
      if (expReq) begin
        checks++; if (hcB !== 5'(hM) || vcB !== 4'(vM))
          begin errors++; $display("[TB] FAIL b_coord cyc %0d: got (%0d,%0d) expected (%0d,%0d)", cyc, hcB, vcB, hM, vM); end
      end
      if (tickNow) begin
        tickIdx++;
        exp = dispQ.pop_front();
        checks++; if ({blankB, hsB, vsB, rgbB} !== exp)
          begin errors++; $display("[TB] FAIL b_display tick %0d: got blank %b hs %b vs %b rgb %h expected blank %b hs %b vs %b rgb %h",
                                   tickIdx, blankB, hsB, vsB, rgbB, exp.blank, exp.hs, exp.vs, exp.rgb); end
        held = exp;
        nxt.blank = !act;
        nxt.hs    = (hM >= B_HA + B_HF && hM < B_HA + B_HF + B_HS) ? 1'b0 : 1'b1;
        nxt.vs    = (vM >= B_VA + B_VF && vM < B_VA + B_VF + B_VS) ? 1'b0 : 1'b1;
        nxt.rgb   = act ? 8'(hM) : 8'h00;
        dispQ.push_back(nxt);
        fbMem[(tickIdx + B_L) % 8] = act ? 8'(hM) : 8'hA5;
        hM++;
        if (hM == B_HT) begin
          hM = 0;
          vM = (vM == B_VT - 1) ? 0 : vM + 1;
        end
      end else begin
        checks++; if ({blankB, hsB, vsB, rgbB} !== held)
          begin errors++; $display("[TB] FAIL b_hold cyc %0d: got %h expected %h", cyc, {blankB, hsB, vsB, rgbB}, held); end
      end
      if (fsB) begin
        if (fsTimes.size() > 0) begin
          checks++; if (reqInFrame != B_HA * B_VA)
            begin errors++; $display("[TB] FAIL b_requests_per_frame: got %0d expected %0d", reqInFrame, B_HA * B_VA); end
        end
        fsTimes.push_back(cyc);
        reqInFrame = 0;
      end
      if (reqB) reqInFrame++;
      enB = !((cyc + 1) >= B_DROP && (cyc + 1) < B_DROP + 37);
      nextB = fbMem[(tickIdx + 1) % 8];
    end
    checks++;
    if (fsTimes.size() < 4) begin
      errors++; $display("[TB] FAIL b_frame_count: got %0d frame starts expected 4", fsTimes.size());
    end else begin
      checks++; if (fsTimes[0] != 2)
        begin errors++; $display("[TB] FAIL b_first_frame: got cyc %0d expected 2", fsTimes[0]); end
      checks++; if (fsTimes[1] - fsTimes[0] != 900)
        begin errors++; $display("[TB] FAIL b_frame_period: got %0d expected 900", fsTimes[1] - fsTimes[0]); end
      checks++; if (fsTimes[2] - fsTimes[1] != 937)
        begin errors++; $display("[TB] FAIL b_frame_period_gap: got %0d expected 937", fsTimes[2] - fsTimes[1]); end
      checks++; if (fsTimes[3] - fsTimes[2] != 900)
        begin errors++; $display("[TB] FAIL b_frame_period_after: got %0d expected 900", fsTimes[3] - fsTimes[2]); end
    end
  endtask

  // Tiny raster: reset during vsync, then exact line and frame timing
  task automatic test_reset_midvsync;
    logic found = 1'b0;
    int firstReq = -1;
    int fsT[$];
    int hsF[$];
    int vsF[$];
    int vsR[$];
    logic pHs, pVs;
    @(negedge clk);
    rstnC = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (vsC === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL c_vsync_seen: got none expected vsync low within 200 clk"); end
    repeat (3) @(negedge clk);
    #2;
    rstnC = 1'b0;
    #1;
    checks++; if ({reqC, hcC, vcC, rgbC, blankC, fsC, hsC, vsC} !== {1'b0, 4'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1})
      begin errors++; $display("[TB] FAIL c_async_reset: got req %b h %0d v %0d rgb %h blank %b fs %b hs %b vs %b expected 0 0 0 00 1 0 1 1",
                               reqC, hcC, vcC, rgbC, blankC, fsC, hsC, vsC); end
    @(negedge clk);
    rstnC = 1'b1;
    pHs = hsC;
    pVs = vsC;
    for (int cyc = 1; cyc <= 220; cyc++) begin
      @(negedge clk);
      if (reqC && firstReq < 0) begin
        firstReq = cyc;
        checks++; if (hcC !== 4'd0 || vcC !== 3'd0)
          begin errors++; $display("[TB] FAIL c_first_coord: got (%0d,%0d) expected (0,0)", hcC, vcC); end
      end
      if (fsC) fsT.push_back(cyc);
      if (pHs && !hsC) hsF.push_back(cyc);
      if (pVs && !vsC) vsF.push_back(cyc);
      if (!pVs && vsC) vsR.push_back(cyc);
      pHs = hsC;
      pVs = vsC;
    end
    checks++; if (firstReq != 1) begin errors++; $display("[TB] FAIL c_first_req_cyc: got %0d expected 1", firstReq); end
    checks++;
    if (fsT.size() < 2 || hsF.size() < 2 || vsF.size() < 2 || vsR.size() < 1) begin
      errors++; $display("[TB] FAIL c_edge_counts: got fs %0d hsf %0d vsf %0d vsr %0d expected >=2 >=2 >=2 >=1",
                         fsT.size(), hsF.size(), vsF.size(), vsR.size());
    end else begin
      checks++; if (fsT[0] != 1)
        begin errors++; $display("[TB] FAIL c_first_frame: got cyc %0d expected 1", fsT[0]); end
      checks++; if (fsT[1] - fsT[0] != 98)
        begin errors++; $display("[TB] FAIL c_frame_period: got %0d expected 98", fsT[1] - fsT[0]); end
      checks++; if (hsF[0] != 12)
        begin errors++; $display("[TB] FAIL c_hsync_fall: got cyc %0d expected 12", hsF[0]); end
      checks++; if (hsF[1] - hsF[0] != 14)
        begin errors++; $display("[TB] FAIL c_line_period: got %0d expected 14", hsF[1] - hsF[0]); end
      checks++; if (vsF[0] != 72)
        begin errors++; $display("[TB] FAIL c_vsync_fall: got cyc %0d expected 72", vsF[0]); end
      checks++; if (vsR[0] - vsF[0] != 14)
        begin errors++; $display("[TB] FAIL c_vsync_width: got %0d expected 14", vsR[0] - vsF[0]); end
      checks++; if (vsF[1] - vsF[0] != 98)
        begin errors++; $display("[TB] FAIL c_vsync_period: got %0d expected 98", vsF[1] - vsF[0]); end
    end
  endtask

  initial begin
    $display("[TB] vga_timing_gen_param bench starting");
    test_reset;
    repeat (3) @(negedge clk);
    test_default_line;
    test_fetch_latency_en;
    test_reset_midvsync;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
